flag_ctx_reg: RTL and testbench

// - Parametrised CPU condition-flag register with interrupt context save/restore.
// - Sits in the execute-memory stage: takes ALU flag results with per-flag write masks
//   and explicit SET/CLR masks (SETC/CLRC-style instructions).
// - Pushes flags onto an internal LIFO on interrupt entry and pops them on RTI.
// - Optional half-cycle output: state is written at posedge and published at the

---
 rtl/flag_ctx_reg.sv | 137 +++++++++++++
 tb/tb_flag_ctx_reg.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/flag_ctx_reg.sv
// flag_ctx_reg: CPU condition-flag register with interrupt context save/restore.
//
// The flag state takes ALU results under a per-flag write mask, then
// SETC/CLRC-style force masks (clear beats set, set beats the ALU write).
// Interrupt entry pushes the updated flags onto an internal LIFO, and RTI pops
// them back. With HALF_CYCLE_READ=1 the state is published on the negedge after
// each write, so decode can read the flags within the same cycle.
//
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   i_wr_en      ALU flag write enable
//   i_wr_mask    flags affected by the ALU write
//   i_flags      ALU flag values
//   i_set_mask   force listed flags to 1
//   i_clr_mask   force listed flags to 0
//   i_save       push context (interrupt entry)
//   i_restore    pop context (RTI)
//   o_flags      published flags
//   o_depth      number of saved contexts
//   o_full       o_depth == STACK_DEPTH (combinational)
//   o_empty      o_depth == 0 (combinational)
//   o_ovf_err    sticky: save attempted while full
//   o_unf_err    sticky: restore attempted while empty
//   o_seq_err    sticky: save and restore in the same cycle
module flag_ctx_reg #(
  parameter int unsigned NUM_FLAGS       = 3,
  parameter int unsigned STACK_DEPTH     = 4,
  parameter int unsigned HALF_CYCLE_READ = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_wr_en,
  input  logic [NUM_FLAGS-1:0]                 i_wr_mask,
  input  logic [NUM_FLAGS-1:0]                 i_flags,
  input  logic [NUM_FLAGS-1:0]                 i_set_mask,
  input  logic [NUM_FLAGS-1:0]                 i_clr_mask,
  input  logic                                 i_save,
  input  logic                                 i_restore,
  output logic [NUM_FLAGS-1:0]                 o_flags,
  output logic [$clog2(STACK_DEPTH+1)-1:0]     o_depth,
  output logic                                 o_full,
  output logic                                 o_empty,
  output logic                                 o_ovf_err,
  output logic                                 o_unf_err,
  output logic                                 o_seq_err
);

  localparam int unsigned DW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [NUM_FLAGS-1:0] state;
  logic [NUM_FLAGS-1:0] w_val;
  logic [NUM_FLAGS-1:0] upd;
  logic [NUM_FLAGS-1:0] stack [STACK_DEPTH];
  logic [DW-1:0]        depth;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic [AW-1:0]        push_idx;
  logic [AW-1:0]        top_idx;

  // Next flag value: masked ALU write, then set, then clear.
  always_comb begin
    w_val = state;
    if (i_wr_en) begin
      w_val = (state & ~i_wr_mask) | (i_flags & i_wr_mask);
    end
    upd = (w_val | i_set_mask) & ~i_clr_mask;
  end

  // Stack occupancy and push/pop qualification; a save always wins over a restore.
  always_comb begin
    full     = (depth == DW'(STACK_DEPTH));
    empty    = (depth == DW'(0));
    push     = i_save && !full;
    pop      = i_restore && !i_save && !empty;
    push_idx = AW'(depth);
    top_idx  = AW'(depth - DW'(1));
  end

  // Flag state, context stack and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= '0;
      depth     <= '0;
      o_ovf_err <= 1'b0;
      o_unf_err <= 1'b0;
      o_seq_err <= 1'b0;
      for (int i = 0; i < int'(STACK_DEPTH); i++) begin
        stack[i] <= '0;
      end
    end else begin
      if (pop) begin
        // Restore overrides any same-cycle flag update.
        state <= stack[top_idx];
        depth <= DW'(depth - DW'(1));
      end else begin
        state <= upd;
        if (push) begin
          // The pushed context includes this cycle's update.
          stack[push_idx] <= upd;
          depth           <= DW'(depth + DW'(1));
        end
      end
      if (i_save && full) begin
        o_ovf_err <= 1'b1;
      end
      if (i_restore && !i_save && empty) begin
        o_unf_err <= 1'b1;
      end
      if (i_save && i_restore) begin
        o_seq_err <= 1'b1;
      end
    end
  end

  // Publish either half a cycle late (negedge register) or directly from state.
  generate
    if (HALF_CYCLE_READ != 0) begin : g_half_cycle
      always_ff @(negedge clk) begin
        if (rst) begin
          o_flags <= '0;
        end else begin
          o_flags <= state;
        end
      end
    end else begin : g_direct
      assign o_flags = state;
    end
  endgenerate

  assign o_depth = depth;
  assign o_full  = full;
  assign o_empty = empty;

endmodule

// File: tb/tb_flag_ctx_reg.sv
// Scoreboard bench for flag_ctx_reg: the driver pushes hand-computed expected
// state per cycle, and a negedge monitor pops and compares it once published.
module tb_flag_ctx_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_wr_en = 1'b0;
  logic [2:0] i_wr_mask = '0;
  logic [2:0] i_flags = '0;
  logic [2:0] i_set_mask = '0;
  logic [2:0] i_clr_mask = '0;
  logic       i_save = 1'b0;
  logic       i_restore = 1'b0;
  logic [2:0] o_flags;
  logic [2:0] o_depth;
  logic       o_full;
  logic       o_empty;
  logic       o_ovf_err;
  logic       o_unf_err;
  logic       o_seq_err;

  flag_ctx_reg #(.NUM_FLAGS(3), .STACK_DEPTH(4), .HALF_CYCLE_READ(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (i_wr_en),
    .i_wr_mask  (i_wr_mask),
    .i_flags    (i_flags),
    .i_set_mask (i_set_mask),
    .i_clr_mask (i_clr_mask),
    .i_save     (i_save),
    .i_restore  (i_restore),
    .o_flags    (o_flags),
    .o_depth    (o_depth),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_ovf_err  (o_ovf_err),
    .o_unf_err  (o_unf_err),
    .o_seq_err  (o_seq_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         due;
    logic [2:0] flags;
    logic [2:0] depth;
    logic       ovf;
    logic       unf;
    logic       seq;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // One input vector, held for exactly one posedge.
  task automatic step(input logic r, input logic we, input logic [2:0] m,
                      input logic [2:0] f, input logic [2:0] s, input logic [2:0] c,
                      input logic sv, input logic rs);
    @(negedge clk);
    #2;
    rst = r; i_wr_en = we; i_wr_mask = m; i_flags = f;
    i_set_mask = s; i_clr_mask = c; i_save = sv; i_restore = rs;
  endtask

  // Expected state after the vector just driven, visible at the next negedge.
  task automatic expect_st(input string name, input logic [2:0] fl, input logic [2:0] d,
                           input logic ov, input logic un, input logic sq);
    exp_t e;
    e.name = name; e.due = cyc + 1; e.flags = fl; e.depth = d;
    e.ovf = ov; e.unf = un; e.seq = sq;
    q.push_back(e);
  endtask

  // Monitor: compare every expectation due at this negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        chk({e.name, ".flags"}, int'(o_flags), int'(e.flags));
        chk({e.name, ".depth"}, int'(o_depth), int'(e.depth));
        chk({e.name, ".full"},  int'(o_full),  int'(e.depth == 3'd4));
        chk({e.name, ".empty"}, int'(o_empty), int'(e.depth == 3'd0));
        chk({e.name, ".ovf"},   int'(o_ovf_err), int'(e.ovf));
        chk({e.name, ".unf"},   int'(o_unf_err), int'(e.unf));
        chk({e.name, ".seq"},   int'(o_seq_err), int'(e.seq));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for two cycles.
    step(1, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0);
    step(1, 1, 3'b111, 3'b111, 3'b111, 3'b000, 1, 0);
    expect_st("reset", 3'b000, 3'd0, 0, 0, 0);

    // Masked ALU write with half-cycle publish.
    step(0, 1, 3'b111, 3'b101, 3'b000, 3'b000, 0, 0);
    expect_st("load101", 3'b101, 3'd0, 0, 0, 0);
    step(0, 1, 3'b010, 3'b111, 3'b000, 3'b000, 0, 0);
    expect_st("masked_wr", 3'b111, 3'd0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("half_cycle_old", int'(o_flags), 5);

    // Set/clear priority.
    step(0, 1, 3'b111, 3'b000, 3'b011, 3'b001, 0, 0);
    expect_st("set_clr", 3'b010, 3'd0, 0, 0, 0);
    step(0, 0, 3'b000, 3'b000, 3'b101, 3'b100, 0, 0);
    expect_st("set_clr_nowr", 3'b011, 3'd0, 0, 0, 0);

    // Nesting: three saves then three restores; restore ignores the ALU write.
    step(0, 1, 3'b111, 3'b001, 3'b000, 3'b000, 1, 0);
    expect_st("nest_save1", 3'b001, 3'd1, 0, 0, 0);
    step(0, 1, 3'b111, 3'b110, 3'b000, 3'b000, 1, 0);
    expect_st("nest_save2", 3'b110, 3'd2, 0, 0, 0);
    step(0, 1, 3'b111, 3'b011, 3'b000, 3'b000, 1, 0);
    expect_st("nest_save3", 3'b011, 3'd3, 0, 0, 0);
    step(0, 1, 3'b111, 3'b000, 3'b000, 3'b000, 0, 1);
    expect_st("nest_rst1", 3'b011, 3'd2, 0, 0, 0);
    step(0, 0, 3'b000, 3'b000, 3'b100, 3'b000, 0, 1);
    expect_st("nest_rst2", 3'b110, 3'd1, 0, 0, 0);
    step(0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 1);
    expect_st("nest_rst3", 3'b001, 3'd0, 0, 0, 0);

    // Overflow: five saves into a depth-4 stack.
    step(0, 1, 3'b111, 3'b100, 3'b000, 3'b000, 1, 0);
    expect_st("ovf_s1", 3'b100, 3'd1, 0, 0, 0);
    step(0, 1, 3'b111, 3'b010, 3'b000, 3'b000, 1, 0);
    expect_st("ovf_s2", 3'b010, 3'd2, 0, 0, 0);
    step(0, 1, 3'b111, 3'b001, 3'b000, 3'b000, 1, 0);
    expect_st("ovf_s3", 3'b001, 3'd3, 0, 0, 0);
    step(0, 1, 3'b111, 3'b111, 3'b000, 3'b000, 1, 0);
    expect_st("ovf_s4", 3'b111, 3'd4, 0, 0, 0);
    step(0, 1, 3'b111, 3'b000, 3'b000, 3'b000, 1, 0);
    expect_st("ovf_s5", 3'b000, 3'd4, 1, 0, 0);
    step(0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 1);
    expect_st("ovf_top", 3'b111, 3'd3, 1, 0, 0);
    step(0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 1);
    expect_st("ovf_pop2", 3'b001, 3'd2, 1, 0, 0);
    step(0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 1);
    expect_st("ovf_pop3", 3'b010, 3'd1, 1, 0, 0);
    step(0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 1);
    expect_st("ovf_pop4", 3'b100, 3'd0, 1, 0, 0);

    // Underflow: restore on empty falls through to the normal update.
    step(0, 1, 3'b111, 3'b101, 3'b000, 3'b000, 0, 1);
    expect_st("unf", 3'b101, 3'd0, 1, 1, 0);

    // Simultaneous save and restore at depth 1.
    step(0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 1, 0);
    expect_st("seq_pre", 3'b101, 3'd1, 1, 1, 0);
    step(0, 0, 3'b000, 3'b000, 3'b010, 3'b000, 1, 1);
    expect_st("seq", 3'b111, 3'd2, 1, 1, 1);

    // Reset mid-stack, then verify stale entries are gone.
    step(1, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0);
    expect_st("mid_reset", 3'b000, 3'd0, 0, 0, 0);
    step(0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 1);
    expect_st("post_reset_rti", 3'b000, 3'd0, 0, 1, 0);
    step(0, 1, 3'b111, 3'b110, 3'b000, 3'b000, 1, 0);
    expect_st("post_reset_save", 3'b110, 3'd1, 0, 1, 0);
    step(0, 1, 3'b111, 3'b001, 3'b000, 3'b000, 0, 1);
    expect_st("post_reset_pop", 3'b110, 3'd0, 0, 1, 0);
    step(0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 8 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
